// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART, one line bit per UART_CLK.
// Configurable data width, parity (none/even/odd), 1 or 2 stop bits and a
// minimum idle gap between transmitted frames.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input that feeds
// the internal TX line into the receiver and parks the TX_Serial pin high.
module uart_xcvr_param #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic              UART_CLK,
  input  logic              RST_UART,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              TX_Serial,
  input  logic              RX_Serial,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY_MODE != 0);
  localparam logic ODD_PAR = (PARITY_MODE == 2);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  // TX states
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;
  localparam logic [2:0] TX_GAP    = 3'd5;

  // The final stop bit is driven while the FSM already sits in GAP or IDLE,
  // so a held request can start the next frame straight after it.
  localparam logic [2:0] TX_AFTER_STOP = (GAP_CYCLES != 0) ? TX_GAP : TX_IDLE;
  localparam logic [2:0] TX_STOP_ENTRY = (STOP_BITS == 2) ? TX_STOP : TX_AFTER_STOP;

  // RX states
  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  logic [2:0]        tx_state_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              tx_par_reg;
  logic [CNT_W-1:0]  tx_cnt_reg;
  logic [7:0]        gap_cnt_reg;
  logic              tx_line_reg;

  logic [1:0]        rx_state_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [CNT_W-1:0]  rx_cnt_reg;
  logic              rx_perr_reg;
  logic              rx_ferr_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              rx_parity_err_reg;
  logic              rx_frame_err_reg;
  logic              rx_line;

`ifdef UART_LOOPBACK_EN
  assign rx_line   = loopback ? tx_line_reg : RX_Serial;
  assign TX_Serial = loopback ? 1'b1 : tx_line_reg;
`else
  assign rx_line   = RX_Serial;
  assign TX_Serial = tx_line_reg;
`endif

  assign tx_ready      = (tx_state_reg == TX_IDLE);
  assign rx_busy       = (rx_state_reg != RX_IDLE);
  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_parity_err = rx_parity_err_reg;
  assign rx_frame_err  = rx_frame_err_reg;

  // Transmit FSM: captures the word on accept and serialises the frame
  always_ff @(posedge UART_CLK) begin
    if (RST_UART) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_cnt_reg   <= '0;
      gap_cnt_reg  <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_shift_reg <= tx_data;
            tx_par_reg   <= (^tx_data) ^ ODD_PAR;
            tx_line_reg  <= 1'b0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          tx_line_reg  <= tx_shift_reg[0];
          tx_shift_reg <= tx_shift_reg >> 1;
          tx_cnt_reg   <= '0;
          tx_state_reg <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_cnt_reg == LAST_BIT) begin
            if (HAS_PAR) begin
              tx_line_reg  <= tx_par_reg;
              tx_state_reg <= TX_PARITY;
            end else begin
              tx_line_reg  <= 1'b1;
              gap_cnt_reg  <= GAP_LOAD;
              tx_state_reg <= TX_STOP_ENTRY;
            end
          end else begin
            tx_line_reg  <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_cnt_reg   <= tx_cnt_reg + 1'b1;
          end
        end
        TX_PARITY: begin
          tx_line_reg  <= 1'b1;
          gap_cnt_reg  <= GAP_LOAD;
          tx_state_reg <= TX_STOP_ENTRY;
        end
        TX_STOP: begin
          tx_line_reg  <= 1'b1;
          tx_state_reg <= TX_AFTER_STOP;
        end
        TX_GAP: begin
          tx_line_reg <= 1'b1;
          if (gap_cnt_reg == 8'd0) begin
            tx_state_reg <= TX_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: begin
          tx_line_reg  <= 1'b1;
          tx_state_reg <= TX_IDLE;
        end
      endcase
    end
  end

  // Receive FSM: start detect, LSB-first shift, parity and stop checking
  always_ff @(posedge UART_CLK) begin
    if (RST_UART) begin
      rx_state_reg      <= RX_IDLE;
      rx_shift_reg      <= '0;
      rx_cnt_reg        <= '0;
      rx_perr_reg       <= 1'b0;
      rx_ferr_reg       <= 1'b0;
      rx_data_reg       <= '0;
      rx_valid_reg      <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_frame_err_reg  <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_line) begin
            rx_cnt_reg   <= '0;
            rx_perr_reg  <= 1'b0;
            rx_ferr_reg  <= 1'b0;
            rx_state_reg <= RX_DATA;
          end
        end
        RX_DATA: begin
          rx_shift_reg <= {rx_line, rx_shift_reg[DATA_W-1:1]};
          if (rx_cnt_reg == LAST_BIT) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_PARITY: begin
          rx_perr_reg  <= rx_line ^ (^rx_shift_reg) ^ ODD_PAR;
          rx_state_reg <= RX_STOP;
        end
        RX_STOP: begin
          if (rx_cnt_reg == LAST_STOP) begin
            rx_valid_reg      <= 1'b1;
            rx_data_reg       <= rx_shift_reg;
            rx_parity_err_reg <= rx_perr_reg;
            rx_frame_err_reg  <= rx_ferr_reg | ~rx_line;
            rx_state_reg      <= RX_IDLE;
          end else begin
            rx_ferr_reg <= rx_ferr_reg | ~rx_line;
            rx_cnt_reg  <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule
